// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared types and defaults for the counter command sequencer.
package counter_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } seq_state_e;

  typedef struct packed {
    cmd_op_e                 op;
    logic [DEF_DATA_W-1:0]   arg;
  } seq_cmd_t;

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Command handshake bundle between a command source and the sequencer.
interface counter_cmd_sequencer_if
  import counter_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_cmd_sequencer_fifo.sv
// Small synchronous command FIFO; head entry is visible combinationally on rdata.
module seq_cmd_fifo
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 2,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; emptiness is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/counter_cmd_sequencer.sv
// Queues LOAD/UP/DOWN/HOLD commands and replays them onto an up/down counter's pins.
// Define CNT_SEQ_STATS_EN to add the 16-bit retired_cnt output.
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  counter_cmd_sequencer_if.slave  cmd,
  output logic [DATA_W-1:0]       data_in,
  output logic                    load,
  output logic                    enable,
  output logic                    up_down,
  output logic                    busy,
  output logic                    cmd_done
`ifdef CNT_SEQ_STATS_EN
  ,
  output logic [15:0]             retired_cnt
`endif
);
  localparam int FIFO_W = DATA_W + 2;

  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] LOAD = S_LOAD;
  localparam logic [1:0] RUN  = S_RUN;
  localparam logic [1:0] HOLD = S_HOLD;

  logic [1:0]            state;
  logic [DATA_W-1:0]     rem;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  finishing;
  logic [FIFO_W-1:0]     head;
  logic [1:0]            head_op;
  logic [DATA_W-1:0]     head_arg;
  logic [$clog2(DEPTH):0] count;

  seq_cmd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd.cmd_op, cmd.cmd_arg}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_op       = head[FIFO_W-1 -: 2];
  assign head_arg      = head[DATA_W-1:0];
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign busy          = (state != IDLE) || (count != '0);

  // A command is in its last active cycle when it is a LOAD or its remaining count hit zero.
  assign finishing = (state == LOAD) || (((state == RUN) || (state == HOLD)) && (rem == '0));
  assign pop       = ((state == IDLE) || finishing) && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rem      <= '0;
      data_in  <= '0;
      load     <= 1'b0;
      enable   <= 1'b0;
      up_down  <= 1'b0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= finishing;
      if (pop) begin
        case (head_op)
          OP_LOAD: begin
            state   <= LOAD;
            data_in <= head_arg;
            load    <= 1'b1;
            enable  <= 1'b0;
            rem     <= '0;
          end
          OP_UP, OP_DOWN: begin
            load <= 1'b0;
            if (head_arg == '0) begin
              // Zero-length run behaves as a one-cycle quiet slot.
              state  <= HOLD;
              enable <= 1'b0;
              rem    <= '0;
            end else begin
              state   <= RUN;
              enable  <= 1'b1;
              up_down <= (head_op == OP_UP);
              rem     <= head_arg - DATA_W'(1);
            end
          end
          default: begin
            state  <= HOLD;
            load   <= 1'b0;
            enable <= 1'b0;
            rem    <= (head_arg == '0) ? '0 : head_arg - DATA_W'(1);
          end
        endcase
      end else if (finishing) begin
        state  <= IDLE;
        load   <= 1'b0;
        enable <= 1'b0;
      end else if (state != IDLE) begin
        rem <= rem - DATA_W'(1);
      end
    end
  end

`ifdef CNT_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_cnt <= '0;
    else if (finishing) retired_cnt <= retired_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
- Upstream stage of the up/down counter.
- Accepts commands over a valid/ready handshake and buffers them in a small FIFO.
- Executes each command by driving the counter's data_in, load, enable and up_down pins cycle by cycle.
- Lets testbench agents and higher-level control issue "load X, count up N, hold M" sequences without cycle-accurate pin wiggling.

Parameters:
- DATA_W, 8, width of counter data_in and of command argument.
- DEPTH, 4, command FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears FIFO, FSM and all outputs.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- cmd_arg  input  DATA_W  LOAD: value; UP/DOWN/HOLD: cycle count.
- data_in  output  DATA_W  to counter data_in.
- load  output  1  to counter load.
- enable  output  1  to counter enable.
- up_down  output  1  to counter up_down (1 = up).
- busy  output  1  FSM not IDLE or FIFO non-empty.
- cmd_done  output  1  one-cycle pulse per retired command.

Behaviour:
- Reset values: cmd_ready=1, data_in=0, load=0, enable=0, up_down=0, busy=0, cmd_done=0. FIFO empty, FSM in IDLE.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_op/cmd_arg are sampled on that edge.
  - cmd_ready deasserts the cycle the FIFO reaches DEPTH entries.
  - A push while full is impossible; a pop and push in the same cycle are both honoured, and the count is unchanged.
- All counter-side outputs are registered.
- FSM states: IDLE, LOAD, RUN, HOLD.
- IDLE with FIFO non-empty pops the head on the next edge and enters:
  - LOAD: data_in=arg, load=1 for exactly one cycle.
  - RUN (UP/DOWN): enable=1, up_down=op==UP, for arg cycles.
  - HOLD: all of load/enable low, data_in holds its last value, for arg cycles.
- Latency: a command accepted at edge t into an empty, idle block drives the counter from edge t+1 (first active cycle t+1..t+2).
- Back-to-back: on the last active cycle, if the FIFO is non-empty, pop the next command directly; no idle bubble between commands.
- Otherwise return to IDLE and drive load=0, enable=0.
- Zero count: UP/DOWN/HOLD with arg=0 retire after one cycle with load=0, enable=0.
- cmd_done: asserted for one cycle on the edge the command's final active cycle ends, i.e. concurrent with the next command's first cycle.
- Remaining-cycle counter is DATA_W bits; it loads arg-1 and decrements to 0 with no wrap.
- Reset asserted mid-command: outputs drop to reset values asynchronously and queued commands are discarded.
- data_in keeps its last LOAD value outside LOAD. It is 0 after reset.

Optional Feature:
- Macro CNT_SEQ_STATS_EN.
- When defined, adds output port retired_cnt (16 bits). It increments on every cmd_done, wraps at 0xFFFF, and resets to 0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package counter_seq_pkg holds:
  - enum cmd_op_e {OP_LOAD, OP_UP, OP_DOWN, OP_HOLD};
  - struct seq_cmd_t {op, arg};
  - enum seq_state_e;
  - default DATA_W/DEPTH constants.
- One sub-module: seq_cmd_fifo (synchronous FIFO with push/pop/full/empty/count, same reset).
- The FSM and output registers live in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 -> all outputs at reset values, cmd_ready=1; no command is accepted.
- Push LOAD 0x2A -> load=1, data_in=0x2A for exactly one cycle starting at edge t+1; cmd_done one cycle later; busy drops after.
- Push LOAD 5, UP 3, DOWN 2 back-to-back:
  - load for 1 cycle, then enable=1 up_down=1 for 3 cycles, then enable=1 up_down=0 for 2 cycles, with no gaps;
  - counter reads 5,6,7,8,7,6; three cmd_done pulses.
- Fill: push 5 HOLD 10 commands without popping stall -> cmd_ready low once DEPTH (4) entries are queued (accounting for 1 popped); later commands are accepted once space frees; no loss or duplication.
- UP 0 followed by LOAD 9 -> one idle cycle with a cmd_done pulse, then load of 9.
- Reset asserted during UP 20 at its 7th cycle -> enable falls immediately; after release busy=0 and queued commands are gone. With CNT_SEQ_STATS_EN, retired_cnt=0.
